// File: rtl/cla_sched_pkg.sv
// rtl/cla_sched_pkg.sv - shared types, widths and round-robin pick for the CLA adder scheduler
package cla_sched_pkg;

    localparam int ADDER_W = 32;
    localparam int OP_W    = 64;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_e;

    // First valid index strictly after last, wrapping modulo n; returns last when nothing is valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int                 n);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n) begin
                idx = (int'(last) + i) % n;
                if (!found && valid[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// rtl/carry_look_ahead_adder.sv - 32-bit adder, 4-bit look-ahead groups chained by group carry
module carry_look_ahead_adder
    import cla_sched_pkg::*;
(
    input  logic [ADDER_W-1:0] a,
    input  logic [ADDER_W-1:0] b,
    input  logic               cin,
    output logic [ADDER_W-1:0] sum,
    output logic               cout
);

    logic [ADDER_W-1:0] g;
    logic [ADDER_W-1:0] p;
    logic [ADDER_W:0]   c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < ADDER_W / 4; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        sum  = p ^ c[ADDER_W-1:0];
        cout = c[ADDER_W];
    end

endmodule

// File: rtl/cla_adder_scheduler.sv
// rtl/cla_adder_scheduler.sv - round-robin time-multiplexing of one 32-bit CLA among NREQ requesters
module cla_adder_scheduler
    import cla_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    input  logic [NREQ-1:0]      req_cin,
    input  logic [NREQ-1:0]      req_wide,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [OP_W-1:0]      rsp_sum,
    output logic                 rsp_cout
);

    state_e               state_q, state_d;
    logic [IDW-1:0]       last_grant_q, last_grant_d;
    logic [OP_W-1:0]      a_q, a_d, b_q, b_d;
    logic                 cin_q, cin_d, wide_q, wide_d, carry_q, carry_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [ADDER_W-1:0]   sum_lo_q, sum_lo_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_cout_q, rsp_cout_d;
    logic [IDW-1:0]       rsp_id_q, rsp_id_d;
    logic [OP_W-1:0]      rsp_sum_q, rsp_sum_d;

    logic [IDW-1:0]       grant;
    logic [NREQ-1:0]      ready_c;
    logic [ADDER_W-1:0]   add_a, add_b, add_sum;
    logic                 add_cin, add_cout;

    carry_look_ahead_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        cin_d        = cin_q;
        wide_d       = wide_q;
        id_d         = id_q;
        carry_d      = carry_q;
        sum_lo_d     = sum_lo_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        ready_c      = '0;
        add_a        = '0;
        add_b        = '0;
        add_cin      = 1'b0;
        grant        = IDW'(rr_pick(MAX_REQ'(req_valid), 3'(last_grant_q), NREQ));

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    ready_c[grant] = 1'b1;
                    a_d            = req_a[int'(grant)*OP_W +: OP_W];
                    b_d            = req_b[int'(grant)*OP_W +: OP_W];
                    cin_d          = req_cin[grant];
                    wide_d         = req_wide[grant];
                    id_d           = grant;
                    last_grant_d   = grant;
                    state_d        = LO;
                end
            end
            LO: begin
                add_a    = a_q[ADDER_W-1:0];
                add_b    = b_q[ADDER_W-1:0];
                add_cin  = cin_q;
                sum_lo_d = add_sum;
                carry_d  = add_cout;
                if (wide_q) begin
                    state_d = HI;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = id_q;
                    rsp_sum_d   = {{(OP_W-ADDER_W){1'b0}}, add_sum};
                    rsp_cout_d  = add_cout;
                    state_d     = RESP;
                end
            end
            HI: begin
                add_a       = a_q[OP_W-1:ADDER_W];
                add_b       = b_q[OP_W-1:ADDER_W];
                add_cin     = carry_q;
                carry_d     = add_cout;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_sum_d   = {add_sum, sum_lo_q};
                rsp_cout_d  = add_cout;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The reset gate keeps the accept strobe quiet while the async reset is held.
    assign req_ready = rst_n ? ready_c : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            wide_q       <= 1'b0;
            id_q         <= '0;
            carry_q      <= 1'b0;
            sum_lo_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cin_q        <= cin_d;
            wide_q       <= wide_d;
            id_q         <= id_d;
            carry_q      <= carry_d;
            sum_lo_q     <= sum_lo_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

endmodule
